vz_image_loader: RTL and testbench



---
 rtl/laser310_pkg.sv | 23 ++
 rtl/vz_ram_writer.sv | 48 ++++
 rtl/vz_image_loader.sv | 196 +++++++++++++++++++
 tb/tb_vz_image_loader.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser310_pkg.sv
// Shared definitions for the LASER310 VZ snapshot loader.
// Holds the loader state encoding, VZ file-type codes, the BASIC system
// variable addresses, and the default header geometry and download index.
package laser310_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHold,
    StHeader,
    StData,
    StPatch,
    StFinish,
    StErr
  } vz_state_e;

  localparam logic [7:0]  VZ_TYPE_BASIC       = 8'hF0;
  localparam logic [7:0]  VZ_TYPE_BIN         = 8'hF1;
  localparam logic [15:0] BASIC_START_PTR_DEF = 16'h78A4;
  localparam logic [15:0] BASIC_END_PTR_DEF   = 16'h78F9;
  localparam int unsigned VZ_HDR_LEN          = 24;
  localparam logic [7:0]  VZ_INDEX_DEF        = 8'd1;

endpackage

// File: rtl/vz_ram_writer.sv
// Single-entry RAM write holding register.
// A request is accepted only while nothing is pending; the captured address
// and data are presented with we_o until the RAM acknowledges, and we_o drops
// the cycle after the acknowledge. pending_o doubles as download back-pressure.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   req_i/addr_i/data_i : write request (ignored while pending)
//   ack_i             : RAM accepted the write this cycle
//   pending_o         : a write is outstanding
//   we_o/addr_o/data_o : RAM write port
module vz_ram_writer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  data_i,
  input  logic        ack_i,
  output logic        pending_o,
  output logic        we_o,
  output logic [15:0] addr_o,
  output logic [7:0]  data_o
);

  logic        pending_q;
  logic [15:0] addr_q;
  logic [7:0]  data_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else if (pending_q) begin
      if (ack_i) begin
        pending_q <= 1'b0;
      end
    end else if (req_i) begin
      pending_q <= 1'b1;
      addr_q    <= addr_i;
      data_q    <= data_i;
    end
  end

  assign pending_o = pending_q;
  assign we_o      = pending_q;
  assign addr_o    = addr_q;
  assign data_o    = data_q;

endmodule

// File: rtl/vz_image_loader.sv
// VZ snapshot loader: parses a VZ file streamed over the hps_io download
// channel, holds the Z80 off the bus, writes the payload to RAM at the header
// start address, then patches the BASIC pointers (type F0) or requests a jump
// to the entry point (type F1).
//   clk_sys, reset                  : clock, asynchronous active-high reset
//   dn_download/dn_index/dn_wr/dn_addr/dn_data : hps_io download stream
//   dn_wait                         : back-pressure to hps_io
//   cpu_hold/hold_ack               : CPU bus hold request / grant
//   ram_we/ram_addr/ram_din/ram_ack : RAM write port with handshake
//   exec_req/exec_addr              : one-cycle jump request and target
//   busy, error                     : status (error sticky until next load)
module vz_image_loader
  import laser310_pkg::*;
#(
  parameter logic [7:0]  VZ_INDEX        = VZ_INDEX_DEF,
  parameter int unsigned HDR_LEN         = VZ_HDR_LEN,
  parameter logic [15:0] BASIC_START_PTR = BASIC_START_PTR_DEF,
  parameter logic [15:0] BASIC_END_PTR   = BASIC_END_PTR_DEF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        dn_download,
  input  logic [7:0]  dn_index,
  input  logic        dn_wr,
  input  logic [15:0] dn_addr,
  input  logic [7:0]  dn_data,
  output logic        dn_wait,
  output logic        cpu_hold,
  input  logic        hold_ack,
  output logic        ram_we,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_din,
  input  logic        ram_ack,
  output logic        exec_req,
  output logic [15:0] exec_addr,
  output logic        busy,
  output logic        error
);

  // Type and start address occupy the last three header bytes.
  localparam logic [15:0] OffType  = 16'(HDR_LEN - 3);
  localparam logic [15:0] OffStrLo = 16'(HDR_LEN - 2);
  localparam logic [15:0] OffStrHi = 16'(HDR_LEN - 1);
  localparam logic [15:0] HdrLen16 = 16'(HDR_LEN);

  vz_state_e   state_q, state_d;
  logic        dl_q;
  logic [7:0]  type_q, type_d;
  logic [15:0] start_q, start_d;
  logic [15:0] end_q, end_d;
  logic        error_q, error_d;
  logic [1:0]  patch_idx_q, patch_idx_d;

  logic        wr_req;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_pending;
  logic [15:0] data_addr;

  // Payload offset maps onto RAM with natural 16-bit wrap.
  assign data_addr = start_q + (dn_addr - HdrLen16);

  vz_ram_writer u_writer (
    .clk_i     (clk_sys),
    .rst_i     (reset),
    .req_i     (wr_req),
    .addr_i    (wr_addr),
    .data_i    (wr_data),
    .ack_i     (ram_ack),
    .pending_o (wr_pending),
    .we_o      (ram_we),
    .addr_o    (ram_addr),
    .data_o    (ram_din)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      dl_q        <= 1'b0;
      type_q      <= '0;
      start_q     <= '0;
      end_q       <= '0;
      error_q     <= 1'b0;
      patch_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      dl_q        <= dn_download;
      type_q      <= type_d;
      start_q     <= start_d;
      end_q       <= end_d;
      error_q     <= error_d;
      patch_idx_q <= patch_idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    start_d     = start_q;
    end_d       = end_q;
    error_d     = error_q;
    patch_idx_d = patch_idx_q;
    wr_req      = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;

    unique case (state_q)
      StIdle: begin
        if (dn_download && !dl_q && (dn_index == VZ_INDEX)) begin
          state_d = StHold;
          error_d = 1'b0;
        end
      end
      StHold: begin
        if (!dn_download) begin
          state_d = StErr;
        end else if (hold_ack) begin
          state_d = StHeader;
        end
      end
      StHeader: begin
        if (!dn_download) begin
          state_d = StErr;
        end else if (dn_wr) begin
          if (dn_addr == OffType) begin
            type_d = dn_data;
          end
          if (dn_addr == OffStrLo) begin
            start_d[7:0] = dn_data;
          end
          if (dn_addr == OffStrHi) begin
            start_d[15:8] = dn_data;
            // An empty payload leaves end equal to start.
            end_d   = {dn_data, start_q[7:0]};
            state_d = StData;
          end
        end
      end
      StData: begin
        if (dn_wr) begin
          if (wr_pending) begin
            // Byte arrived while the previous one is still outstanding.
            error_d = 1'b1;
          end else begin
            wr_req  = 1'b1;
            wr_addr = data_addr;
            wr_data = dn_data;
            end_d   = data_addr + 16'd1;
          end
        end else if (!dn_download && !wr_pending) begin
          if (type_q == VZ_TYPE_BASIC) begin
            state_d     = StPatch;
            patch_idx_d = '0;
          end else if (type_q == VZ_TYPE_BIN) begin
            state_d = StFinish;
          end else begin
            state_d = StErr;
          end
        end
      end
      StPatch: begin
        if (!wr_pending) begin
          wr_req = 1'b1;
          unique case (patch_idx_q)
            2'd0: begin wr_addr = BASIC_START_PTR;         wr_data = start_q[7:0];  end
            2'd1: begin wr_addr = BASIC_START_PTR + 16'd1; wr_data = start_q[15:8]; end
            2'd2: begin wr_addr = BASIC_END_PTR;           wr_data = end_q[7:0];    end
            2'd3: begin wr_addr = BASIC_END_PTR + 16'd1;   wr_data = end_q[15:8];   end
          endcase
        end else if (ram_ack) begin
          if (patch_idx_q == 2'd3) begin
            state_d = StFinish;
          end else begin
            patch_idx_d = patch_idx_q + 2'd1;
          end
        end
      end
      StFinish: state_d = StIdle;
      StErr:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if ((state_d == StErr) && (state_q != StErr)) begin
      error_d = 1'b1;
    end
  end

  assign cpu_hold  = (state_q == StHold) || (state_q == StHeader) ||
                     (state_q == StData) || (state_q == StPatch);
  assign busy      = cpu_hold || (state_q == StFinish);
  assign dn_wait   = (state_q == StHold) || wr_pending;
  assign exec_req  = (state_q == StFinish) && (type_q == VZ_TYPE_BIN);
  assign exec_addr = start_q;
  assign error     = error_q;

endmodule

// File: tb/tb_vz_image_loader.sv
module tb_vz_image_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        dn_download = 1'b0;
  logic [7:0]  dn_index = 8'd0;
  logic        dn_wr = 1'b0;
  logic [15:0] dn_addr = '0;
  logic [7:0]  dn_data = '0;
  logic        dn_wait;
  logic        cpu_hold;
  logic        hold_ack;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_ack;
  logic        exec_req;
  logic [15:0] exec_addr;
  logic        busy;
  logic        error;

  int checks = 0;
  int failures = 0;

  always #5 clk_sys = ~clk_sys;

  vz_image_loader dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .dn_download (dn_download),
    .dn_index    (dn_index),
    .dn_wr       (dn_wr),
    .dn_addr     (dn_addr),
    .dn_data     (dn_data),
    .dn_wait     (dn_wait),
    .cpu_hold    (cpu_hold),
    .hold_ack    (hold_ack),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_din     (ram_din),
    .ram_ack     (ram_ack),
    .exec_req    (exec_req),
    .exec_addr   (exec_addr),
    .busy        (busy),
    .error       (error)
  );

  // Environment knobs
  int ack_delay = 0;
  int hold_delay = 0;

  // Image under test and reference expectations
  logic [7:0]  img [0:63];
  int          img_len;
  logic [23:0] exp_q [$];
  logic        exp_err;
  int          exp_exec;
  logic [15:0] exp_exec_addr;

  // Monitor observations (monotonic; tests take baselines)
  logic [23:0] obs_q [$];
  int          exec_cnt = 0;
  logic [15:0] exec_seen = '0;
  int          stab_err = 0;
  int          hold_err = 0;
  int          hold_wait_cycles = 0;
  int          busy_cycles = 0;
  int obs_base, exec_base, stab_base, hold_base, hwait_base, busy_base;
  logic [23:0] bad_obs, bad_exp;

  // RAM responder: acknowledges each write after ack_delay cycles
  initial begin
    int cnt;
    cnt = 0;
    ram_ack = 1'b0;
    forever begin
      @(posedge clk_sys); #1;
      if (ram_ack) begin
        ram_ack = 1'b0;
      end else if (ram_we === 1'b1) begin
        if (cnt >= ack_delay) begin
          ram_ack = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // CPU model: grants the bus hold_delay cycles after the request
  initial begin
    int cnt;
    cnt = 0;
    hold_ack = 1'b0;
    forever begin
      @(posedge clk_sys); #1;
      if (cpu_hold !== 1'b1) begin
        hold_ack = 1'b0;
        cnt = 0;
      end else if (!hold_ack) begin
        if (cnt >= hold_delay) hold_ack = 1'b1;
        else cnt++;
      end
    end
  end

  // Protocol monitor, sampled mid-cycle
  logic        p_we = 1'b0, p_ack = 1'b0, p_hold = 1'b0;
  logic [15:0] p_addr = '0;
  logic [7:0]  p_din = '0;
  always @(negedge clk_sys) begin
    if (reset) begin
      p_we = 1'b0; p_ack = 1'b0; p_hold = 1'b0;
    end else begin
      if (ram_we && ram_ack) obs_q.push_back({ram_addr, ram_din});
      if (exec_req) begin
        exec_cnt++;
        exec_seen = exec_addr;
        if (cpu_hold || !p_hold) stab_err++;
      end
      if (p_we && !p_ack && (ram_we !== 1'b1 || ram_addr !== p_addr || ram_din !== p_din))
        stab_err++;
      if (p_we && p_ack && ram_we) stab_err++;
      if (cpu_hold && !hold_ack) begin
        if (dn_wait !== 1'b1 || ram_we) hold_err++;
        else hold_wait_cycles++;
      end
      if (busy) busy_cycles++;
      p_we = ram_we; p_ack = ram_ack; p_hold = cpu_hold;
      p_addr = ram_addr; p_din = ram_din;
    end
  end

  task automatic build_image(input logic [7:0] typ, input logic [15:0] start, input int n);
    for (int i = 0; i < 24 + n; i++) img[i] = 8'($urandom);
    img[21] = typ;
    img[22] = start[7:0];
    img[23] = start[15:8];
    img_len = 24 + n;
  endtask

  // Reference: what a VZ load of img[0:img_len-1] should do to RAM and status
  task automatic model(input logic [7:0] idx);
    logic [7:0]  typ;
    logic [15:0] start, fin;
    exp_q.delete();
    exp_err = 1'b0;
    exp_exec = 0;
    exp_exec_addr = '0;
    if (idx != 8'd1) return;
    if (img_len < 24) begin
      exp_err = 1'b1;
      return;
    end
    typ   = img[21];
    start = {img[23], img[22]};
    for (int i = 0; i < img_len - 24; i++) exp_q.push_back({start + 16'(i), img[24 + i]});
    fin = start + 16'(img_len - 24);
    if (typ == 8'hF0) begin
      exp_q.push_back({16'h78A4, start[7:0]});
      exp_q.push_back({16'h78A5, start[15:8]});
      exp_q.push_back({16'h78F9, fin[7:0]});
      exp_q.push_back({16'h78FA, fin[15:8]});
    end else if (typ == 8'hF1) begin
      exp_exec = 1;
      exp_exec_addr = start;
    end else begin
      exp_err = 1'b1;
    end
  endtask

  function automatic int count_write_diffs();
    int d = 0;
    int n_obs = obs_q.size() - obs_base;
    int n = (n_obs > exp_q.size()) ? n_obs : exp_q.size();
    bad_obs = '0;
    bad_exp = '0;
    for (int i = 0; i < n; i++) begin
      if (i >= n_obs || i >= exp_q.size() || obs_q[obs_base + i] !== exp_q[i]) begin
        if (d == 0) begin
          if (i < n_obs) bad_obs = obs_q[obs_base + i];
          if (i < exp_q.size()) bad_exp = exp_q[i];
        end
        d++;
      end
    end
    return d;
  endfunction

  task automatic send_byte(input logic [15:0] a, input logic [7:0] d, inout int to);
    int n = 0;
    while (dn_wait === 1'b1 && n < 300) begin
      @(posedge clk_sys); #1;
      n++;
    end
    if (n >= 300) to++;
    dn_wr = 1'b1; dn_addr = a; dn_data = d;
    @(posedge clk_sys); #1;
    dn_wr = 1'b0;
  endtask

  task automatic snap();
    obs_base = obs_q.size(); exec_base = exec_cnt; stab_base = stab_err;
    hold_base = hold_err; hwait_base = hold_wait_cycles; busy_base = busy_cycles;
  endtask

  task automatic start_download(input logic [7:0] idx);
    @(posedge clk_sys); #1;
    dn_index = idx;
    dn_download = 1'b1;
    @(posedge clk_sys); #1;
  endtask

  task automatic end_download(inout int to);
    int n = 0;
    dn_download = 1'b0;
    @(posedge clk_sys); #1;
    while (busy === 1'b1 && n < 500) begin
      @(posedge clk_sys); #1;
      n++;
    end
    if (n >= 500) to++;
    repeat (3) @(posedge clk_sys);
    #1;
  endtask

  task automatic run_load(input logic [7:0] idx, input int ackd, input int holdd, output int to);
    to = 0;
    ack_delay = ackd;
    hold_delay = holdd;
    snap();
    start_download(idx);
    for (int i = 0; i < img_len; i++) send_byte(16'(i), img[i], to);
    end_download(to);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
    checks++;
    if ({dn_wait, cpu_hold, ram_we, ram_addr, ram_din, exec_req, exec_addr, busy, error} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=0", {dn_wait, cpu_hold, ram_we, ram_addr,
               ram_din, exec_req, exec_addr, busy, error});
    end
    reset = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    checks++;
    if ({dn_wait, cpu_hold, ram_we, busy, error} !== 5'b0) begin
      failures++;
      $display("FAIL idle_after_reset got=%b want=00000", {dn_wait, cpu_hold, ram_we, busy, error});
    end
  endtask

  task automatic test_basic();
    int to, d, n;
    logic [95:0] got_p;
    build_image(8'hF0, 16'h7AE9, 5);
    model(8'd1);
    run_load(8'd1, 3, 2, to);
    d = count_write_diffs();
    n = obs_q.size() - obs_base;
    checks++;
    if (to !== 0) begin failures++; $display("FAIL basic_timeout got=%0d want=0", to); end
    checks++;
    if (d !== 0) begin
      failures++;
      $display("FAIL basic_writes diffs=%0d got=%h want=%h", d, bad_obs, bad_exp);
    end
    got_p = '0;
    if (n >= 4) got_p = {obs_q[obs_q.size()-4], obs_q[obs_q.size()-3],
                         obs_q[obs_q.size()-2], obs_q[obs_q.size()-1]};
    checks++;
    if (n !== 9 || got_p !== {24'h78A4E9, 24'h78A57A, 24'h78F9EE, 24'h78FA7A}) begin
      failures++;
      $display("FAIL basic_patch count=%0d got=%h want=9 78a4e9_78a57a_78f9ee_78fa7a", n, got_p);
    end
    checks++;
    if (exec_cnt - exec_base !== 0) begin
      failures++; $display("FAIL basic_no_exec got=%0d want=0", exec_cnt - exec_base);
    end
    checks++;
    if ({busy, cpu_hold, error} !== 3'b000) begin
      failures++; $display("FAIL basic_status got=%b want=000", {busy, cpu_hold, error});
    end
    checks++;
    if (stab_err - stab_base !== 0) begin
      failures++; $display("FAIL basic_handshake got=%0d want=0", stab_err - stab_base);
    end
  endtask

  task automatic test_binary();
    int to, d;
    build_image(8'hF1, 16'h8000, 3);
    model(8'd1);
    run_load(8'd1, 1, 0, to);
    d = count_write_diffs();
    checks++;
    if (to !== 0 || d !== 0 || obs_q.size() - obs_base !== 3) begin
      failures++;
      $display("FAIL bin_writes to=%0d diffs=%0d got=%h want=%h", to, d, bad_obs, bad_exp);
    end
    checks++;
    if (exec_cnt - exec_base !== 1 || exec_seen !== 16'h8000) begin
      failures++;
      $display("FAIL bin_exec got=%0d@%h want=1@8000", exec_cnt - exec_base, exec_seen);
    end
    checks++;
    if ({busy, cpu_hold, error, stab_err - stab_base} !== '0) begin
      failures++;
      $display("FAIL bin_status got=%b%b%b hs=%0d want=000 hs=0", busy, cpu_hold, error,
               stab_err - stab_base);
    end
  endtask

  task automatic test_truncated();
    int to;
    build_image(8'hF0, 16'h7000, 2);
    img_len = 10;
    model(8'd1);
    run_load(8'd1, 0, 1, to);
    checks++;
    if (to !== 0 || obs_q.size() - obs_base !== 0) begin
      failures++;
      $display("FAIL trunc_writes to=%0d got=%0d want=0", to, obs_q.size() - obs_base);
    end
    checks++;
    if ({error, cpu_hold, busy} !== {exp_err, 2'b00}) begin
      failures++; $display("FAIL trunc_status got=%b want=%b00", {error, cpu_hold, busy}, exp_err);
    end
  endtask

  task automatic test_hold_latency();
    int to, d;
    build_image(8'hF1, 16'($urandom), 2);
    model(8'd1);
    run_load(8'd1, 2, 20, to);
    d = count_write_diffs();
    checks++;
    if (hold_err - hold_base !== 0 || hold_wait_cycles - hwait_base < 20) begin
      failures++;
      $display("FAIL hold_wait bad=%0d waited=%0d want bad=0 waited>=20",
               hold_err - hold_base, hold_wait_cycles - hwait_base);
    end
    checks++;
    if (to !== 0 || d !== 0 || exec_cnt - exec_base !== 1 || exec_seen !== exp_exec_addr) begin
      failures++;
      $display("FAIL hold_result to=%0d diffs=%0d exec=%0d@%h want 0 0 1@%h", to, d,
               exec_cnt - exec_base, exec_seen, exp_exec_addr);
    end
  endtask

  task automatic test_wrap();
    int to, d, n;
    logic [95:0] got_a;
    build_image(8'hF0, 16'hFFFE, 4);
    model(8'd1);
    run_load(8'd1, 0, 0, to);
    d = count_write_diffs();
    n = obs_q.size() - obs_base;
    got_a = '0;
    if (n >= 4) got_a = {obs_q[obs_base][23:8], obs_q[obs_base+1][23:8],
                         obs_q[obs_base+2][23:8], obs_q[obs_base+3][23:8], 32'h0};
    checks++;
    if (got_a !== {16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 32'h0}) begin
      failures++; $display("FAIL wrap_addrs got=%h want=fffeffff00000001", got_a[95:32]);
    end
    checks++;
    if (n !== 8 || obs_q[obs_q.size()-2] !== 24'h78F902 || obs_q[obs_q.size()-1] !== 24'h78FA00)
    begin
      failures++; $display("FAIL wrap_end_ptr count=%0d want end ptr 0002", n);
    end
    checks++;
    if (to !== 0 || d !== 0) begin
      failures++; $display("FAIL wrap_model diffs=%0d got=%h want=%h", d, bad_obs, bad_exp);
    end
  endtask

  task automatic test_violation();
    int to = 0;
    build_image(8'hF1, 16'h9000, 2);
    ack_delay = 2;
    hold_delay = 0;
    snap();
    start_download(8'd1);
    for (int i = 0; i < 25; i++) send_byte(16'(i), img[i], to);
    // Second payload byte issued while the first write is still outstanding
    dn_wr = 1'b1; dn_addr = 16'd25; dn_data = img[25];
    @(posedge clk_sys); #1;
    dn_wr = 1'b0;
    end_download(to);
    checks++;
    if (to !== 0 || obs_q.size() - obs_base !== 1 || obs_q[obs_q.size()-1] !== {16'h9000, img[24]})
    begin
      failures++;
      $display("FAIL violation_drop to=%0d writes=%0d want=1", to, obs_q.size() - obs_base);
    end
    checks++;
    if (error !== 1'b1 || exec_cnt - exec_base !== 1) begin
      failures++;
      $display("FAIL violation_error got err=%b exec=%0d want err=1 exec=1", error,
               exec_cnt - exec_base);
    end
  endtask

  task automatic test_random();
    int to, d, r;
    logic [7:0] typ;
    for (int it = 0; it < 8; it++) begin
      r = $urandom_range(0, 2);
      typ = (r == 0) ? 8'hF0 : (r == 1) ? 8'hF1 : 8'($urandom_range(0, 8'hEF));
      build_image(typ, 16'($urandom), $urandom_range(0, 6));
      model(8'd1);
      run_load(8'd1, $urandom_range(0, 3), $urandom_range(0, 4), to);
      d = count_write_diffs();
      checks++;
      if (to !== 0 || d !== 0 || error !== exp_err || exec_cnt - exec_base !== exp_exec ||
          (exp_exec == 1 && exec_seen !== exp_exec_addr) || stab_err - stab_base !== 0) begin
        failures++;
        $display("FAIL random_%0d type=%h diffs=%0d got=%h want=%h err=%b/%b exec=%0d/%0d",
                 it, typ, d, bad_obs, bad_exp, error, exp_err, exec_cnt - exec_base, exp_exec);
      end
    end
  endtask

  task automatic test_reset_mid();
    int to = 0;
    build_image(8'hF1, 16'h4000, 4);
    ack_delay = 3;
    hold_delay = 1;
    start_download(8'd1);
    for (int i = 0; i < 26; i++) send_byte(16'(i), img[i], to);
    reset = 1'b1;
    #1;
    checks++;
    if (cpu_hold !== 1'b0) begin failures++; $display("FAIL reset_hold_release got=%b want=0", cpu_hold); end
    dn_download = 1'b0;
    @(posedge clk_sys); #1;
    checks++;
    if ({dn_wait, cpu_hold, ram_we, ram_addr, ram_din, exec_req, exec_addr, busy, error} !== '0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=%b want=0", {dn_wait, cpu_hold, ram_we, ram_addr,
               ram_din, exec_req, exec_addr, busy, error});
    end
    reset = 1'b0;
    repeat (2) @(posedge clk_sys);
    build_image(8'hF0, 16'h5000, 3);
    model(8'd0);
    run_load(8'd0, 0, 0, to);
    checks++;
    if (to !== 0 || obs_q.size() - obs_base !== exp_q.size() || busy_cycles - busy_base !== 0 ||
        exec_cnt - exec_base !== 0 || error !== 1'b0) begin
      failures++;
      $display("FAIL index0_ignored writes=%0d busy=%0d exec=%0d err=%b want all 0",
               obs_q.size() - obs_base, busy_cycles - busy_base, exec_cnt - exec_base, error);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_binary();
    test_truncated();
    test_hold_latency();
    test_wrap();
    test_violation();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
